// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: bundles the command handshake, the ALU operand/result
// bus and the status/debug signals of the ALU issue controller.
// The slave modport is the controller's view; master is the driver's view.
interface alu_exec_ctrl_if #(
    parameter int N = 32
);
    logic         iValid;
    logic         oReady;
    logic [2:0]   Op;
    logic [2:0]   Rd;
    logic [2:0]   Rs1;
    logic [2:0]   Rs2;
    logic [N-1:0] AluA;
    logic [N-1:0] AluB;
    logic [2:0]   AluCtrl;
    logic [N-1:0] AluResult;
    logic         AluOverflow;
    logic         Done;
    logic         OvfFlag;
    logic         ErrFlag;
    logic         ClrFlags;
    logic [2:0]   DbgAddr;
    logic [N-1:0] DbgData;

    modport slave (
        input  iValid, Op, Rd, Rs1, Rs2, AluResult, AluOverflow, ClrFlags, DbgAddr,
        output oReady, AluA, AluB, AluCtrl, Done, OvfFlag, ErrFlag, DbgData
    );

    modport master (
        output iValid, Op, Rd, Rs1, Rs2, AluResult, AluOverflow, ClrFlags, DbgAddr,
        input  oReady, AluA, AluB, AluCtrl, Done, OvfFlag, ErrFlag, DbgData
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: register file + issue controller in front of a combinational
// ALU. Each command walks IDLE -> EXEC -> WB (one command per 3 cycles).
// Optional build macro OVF_TRAP_EN: when defined, an add/sub that overflows
// does not write its destination (the overflow flag is still raised).
module alu_exec_ctrl #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic op_is_addsub(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    state_t       state_r, state_nxt_s;
    logic [2:0]   op_q_r, rd_q_r;
    logic [N-1:0] regs_r [8];
    logic [N-1:0] res_q_r;
    logic         ovf_q_r;
    logic [N-1:0] alu_a_r, alu_b_r;
    logic [2:0]   alu_ctrl_r;
    logic         ready_r, done_r, ovf_flag_r, err_flag_r;
    logic         accept_s, wr_en_s, ovf_set_s, err_set_s;
    logic [N-1:0] rs1_data_s, rs2_data_s, dbg_data_s;

    // Register-file read ports; R0 always reads as zero
    always_comb begin
        rs1_data_s = (bus.Rs1 == 3'd0)     ? {N{1'b0}} : regs_r[bus.Rs1];
        rs2_data_s = (bus.Rs2 == 3'd0)     ? {N{1'b0}} : regs_r[bus.Rs2];
        dbg_data_s = (bus.DbgAddr == 3'd0) ? {N{1'b0}} : regs_r[bus.DbgAddr];
    end

    // Next-state logic and command acceptance
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s    = bus.iValid && ready_r;
                state_nxt_s = accept_s ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: state_nxt_s = ST_WB;
            ST_WB:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Write-back enable and flag-set conditions, evaluated during WB
    always_comb begin
        wr_en_s   = 1'b0;
        ovf_set_s = 1'b0;
        err_set_s = 1'b0;
        if (state_r == ST_WB) begin
`ifdef OVF_TRAP_EN
            wr_en_s = op_is_legal(op_q_r) && (rd_q_r != 3'd0)
                      && !(op_is_addsub(op_q_r) && ovf_q_r);
`else
            wr_en_s = op_is_legal(op_q_r) && (rd_q_r != 3'd0);
`endif
            ovf_set_s = ovf_q_r && op_is_addsub(op_q_r);
            err_set_s = !op_is_legal(op_q_r);
        end else begin
            wr_en_s   = 1'b0;
            ovf_set_s = 1'b0;
            err_set_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Latch the accepted command's opcode and destination
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q_r <= 3'd0;
            rd_q_r <= 3'd0;
        end else if (accept_s) begin
            op_q_r <= bus.Op;
            rd_q_r <= bus.Rd;
        end
    end

    // ALU drive: operands loaded on accept so they are valid throughout EXEC,
    // zeroed when EXEC ends. No write is pending in IDLE, so the read is current.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_r    <= {N{1'b0}};
            alu_b_r    <= {N{1'b0}};
            alu_ctrl_r <= 3'd0;
        end else if (accept_s) begin
            alu_a_r    <= rs1_data_s;
            alu_b_r    <= rs2_data_s;
            alu_ctrl_r <= bus.Op;
        end else if (state_r == ST_EXEC) begin
            alu_a_r    <= {N{1'b0}};
            alu_b_r    <= {N{1'b0}};
            alu_ctrl_r <= 3'd0;
        end
    end

    // Capture the ALU result and overflow at the end of EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q_r <= {N{1'b0}};
            ovf_q_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            res_q_r <= bus.AluResult;
            ovf_q_r <= bus.AluOverflow;
        end
    end

    // Registered handshake outputs: ready in IDLE, Done high for the WB cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_nxt_s == ST_IDLE);
            done_r  <= (state_nxt_s == ST_WB);
        end
    end

    // Sticky status flags; a set in the same cycle as a clear takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_flag_r <= 1'b0;
            err_flag_r <= 1'b0;
        end else begin
            if (ovf_set_s)         ovf_flag_r <= 1'b1;
            else if (bus.ClrFlags) ovf_flag_r <= 1'b0;
            if (err_set_s)         err_flag_r <= 1'b1;
            else if (bus.ClrFlags) err_flag_r <= 1'b0;
        end
    end

    // Register file write port; R0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs_r[i] <= {N{1'b0}};
        end else if (wr_en_s) begin
            regs_r[rd_q_r] <= res_q_r;
        end
    end

    assign bus.oReady  = ready_r;
    assign bus.Done    = done_r;
    assign bus.OvfFlag = ovf_flag_r;
    assign bus.ErrFlag = err_flag_r;
    assign bus.AluA    = alu_a_r;
    assign bus.AluB    = alu_b_r;
    assign bus.AluCtrl = alu_ctrl_r;
    assign bus.DbgData = dbg_data_s;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed bench for alu_exec_ctrl with a behavioural ALU.
// Registers are preloaded by issuing add Rx=R0+R0 while the bench ALU returns
// an override value. Build with OVF_TRAP_EN to check the trap variant.
module tb_alu_exec_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    logic        ovr_en;
    logic [31:0] ovr_val;
    logic [31:0] alu_sum, alu_dif;
    logic [31:0] mdl [8];

    alu_exec_ctrl_if #(.N(32)) bus ();

    alu_exec_ctrl #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU, with an override used for register preloading
    always_comb begin
        alu_sum         = bus.AluA + bus.AluB;
        alu_dif         = bus.AluA - bus.AluB;
        bus.AluOverflow = 1'b0;
        bus.AluResult   = 32'hDEADBEEF;
        if (ovr_en) begin
            bus.AluResult = ovr_val;
        end else begin
            case (bus.AluCtrl)
                3'b000: begin
                    bus.AluResult   = alu_sum;
                    bus.AluOverflow = (bus.AluA[31] == bus.AluB[31]) && (alu_sum[31] != bus.AluA[31]);
                end
                3'b001: begin
                    bus.AluResult   = alu_dif;
                    bus.AluOverflow = (bus.AluA[31] != bus.AluB[31]) && (alu_dif[31] != bus.AluA[31]);
                end
                3'b010:  bus.AluResult = bus.AluA & bus.AluB;
                3'b011:  bus.AluResult = bus.AluA ^ bus.AluB;
                3'b101:  bus.AluResult = ($signed(bus.AluA) < $signed(bus.AluB)) ? 32'd1 : 32'd0;
                default: bus.AluResult = 32'hDEADBEEF;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic dbg_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        bus.DbgAddr = addr;
        #1;
        check_eq(tag, bus.DbgData, exp);
    endtask

    // Issue one command and check EXEC/WB/IDLE behaviour cycle by cycle
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input logic [31:0] exp_wb);
        logic [31:0] old_v;
        old_v = mdl[rd];
        @(negedge clk);
        for (int i = 0; i < 8 && bus.oReady !== 1'b1; i++) @(negedge clk);
        check_eq({tag, "_rdy_in"}, {31'd0, bus.oReady}, 32'd1);
        bus.DbgAddr = rd;
        bus.Op      = op;
        bus.Rd      = rd;
        bus.Rs1     = rs1;
        bus.Rs2     = rs2;
        bus.iValid  = 1'b1;
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_exec_rdy"},  {31'd0, bus.oReady}, 32'd0);
        check_eq({tag, "_exec_a"},    bus.AluA, exp_a);
        check_eq({tag, "_exec_b"},    bus.AluB, exp_b);
        check_eq({tag, "_exec_ctrl"}, {29'd0, bus.AluCtrl}, {29'd0, op});
        check_eq({tag, "_exec_done"}, {31'd0, bus.Done}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_wb_done"},   {31'd0, bus.Done}, 32'd1);
        check_eq({tag, "_wb_ctrl"},   {29'd0, bus.AluCtrl}, 32'd0);
        check_eq({tag, "_wb_a"},      bus.AluA, 32'd0);
        check_eq({tag, "_wb_dbgold"}, bus.DbgData, old_v);
        @(negedge clk);
        check_eq({tag, "_idle_done"}, {31'd0, bus.Done}, 32'd0);
        check_eq({tag, "_idle_rdy"},  {31'd0, bus.oReady}, 32'd1);
        check_eq({tag, "_idle_dbg"},  bus.DbgData, exp_wb);
        if (rd != 3'd0) mdl[rd] = exp_wb;
    endtask

    task automatic preload(input logic [2:0] rd, input logic [31:0] val);
        ovr_en  = 1'b1;
        ovr_val = val;
        run_cmd("preload", 3'b000, rd, 3'd0, 3'd0, 32'd0, 32'd0, val);
        ovr_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_ovf_r3;
        n_checks = 0;
        n_fails  = 0;
        ovr_en   = 1'b0;
        ovr_val  = 32'd0;
        for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
        reset        = 1'b1;
        bus.iValid   = 1'b0;
        bus.Op       = 3'd0;
        bus.Rd       = 3'd0;
        bus.Rs1      = 3'd0;
        bus.Rs2      = 3'd0;
        bus.ClrFlags = 1'b0;
        bus.DbgAddr  = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_ready", {31'd0, bus.oReady}, 32'd1);
        check_eq("rst_done",  {31'd0, bus.Done}, 32'd0);
        check_eq("rst_ovf",   {31'd0, bus.OvfFlag}, 32'd0);
        check_eq("rst_err",   {31'd0, bus.ErrFlag}, 32'd0);
        check_eq("rst_alua",  bus.AluA, 32'd0);
        check_eq("rst_ctrl",  {29'd0, bus.AluCtrl}, 32'd0);
        for (int i = 0; i < 8; i++) dbg_check("rst_dbg", i[2:0], 32'd0);

        // Basic arithmetic
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        run_cmd("add",  3'b000, 3'd3, 3'd1, 3'd2, 32'd5, 32'd7, 32'd12);
        run_cmd("sub",  3'b001, 3'd4, 3'd1, 3'd2, 32'd5, 32'd7, 32'hFFFFFFFE);
        run_cmd("slt",  3'b101, 3'd5, 3'd1, 3'd2, 32'd5, 32'd7, 32'd1);
        run_cmd("and",  3'b010, 3'd6, 3'd1, 3'd2, 32'd5, 32'd7, 32'd5);
        run_cmd("xor",  3'b011, 3'd7, 3'd1, 3'd2, 32'd5, 32'd7, 32'd2);
        run_cmd("self", 3'b000, 3'd1, 3'd1, 3'd1, 32'd5, 32'd5, 32'd10);
        check_eq("noflag_ovf", {31'd0, bus.OvfFlag}, 32'd0);
        check_eq("noflag_err", {31'd0, bus.ErrFlag}, 32'd0);

        // Signed overflow on add
        preload(3'd1, 32'h7FFFFFFF);
        preload(3'd2, 32'd1);
`ifdef OVF_TRAP_EN
        exp_ovf_r3 = 32'd12;
`else
        exp_ovf_r3 = 32'h80000000;
`endif
        run_cmd("ovf_add", 3'b000, 3'd3, 3'd1, 3'd2, 32'h7FFFFFFF, 32'd1, exp_ovf_r3);
        check_eq("ovf_flag_set", {31'd0, bus.OvfFlag}, 32'd1);
        check_eq("ovf_err_clr",  {31'd0, bus.ErrFlag}, 32'd0);
        bus.ClrFlags = 1'b1;
        @(negedge clk);
        bus.ClrFlags = 1'b0;
        check_eq("ovf_flag_clr", {31'd0, bus.OvfFlag}, 32'd0);

        // Illegal op with ClrFlags held high: set wins, R6 untouched
        bus.ClrFlags = 1'b1;
        run_cmd("illegal", 3'b110, 3'd6, 3'd1, 3'd2, 32'h7FFFFFFF, 32'd1, 32'd5);
        bus.ClrFlags = 1'b0;
        check_eq("illegal_err", {31'd0, bus.ErrFlag}, 32'd1);
        check_eq("illegal_ovf", {31'd0, bus.OvfFlag}, 32'd0);

        // Write to R0 is discarded (also overflows: flag raised regardless)
        run_cmd("wr_r0", 3'b000, 3'd0, 3'd1, 3'd2, 32'h7FFFFFFF, 32'd1, 32'd0);
        check_eq("wr_r0_ovf", {31'd0, bus.OvfFlag}, 32'd1);
        bus.ClrFlags = 1'b1;
        @(negedge clk);
        bus.ClrFlags = 1'b0;
        check_eq("clr_both_ovf", {31'd0, bus.OvfFlag}, 32'd0);
        check_eq("clr_both_err", {31'd0, bus.ErrFlag}, 32'd0);

        // Back-to-back with iValid held: second accepted exactly 3 cycles later
        @(negedge clk);
        bus.Op = 3'b000; bus.Rd = 3'd3; bus.Rs1 = 3'd2; bus.Rs2 = 3'd2;
        bus.DbgAddr = 3'd4;
        bus.iValid = 1'b1;
        @(posedge clk);
        #1;
        bus.Op = 3'b011; bus.Rd = 3'd4; bus.Rs1 = 3'd3; bus.Rs2 = 3'd2;
        @(negedge clk);
        check_eq("b2b_exec1_ctrl", {29'd0, bus.AluCtrl}, 32'd0);
        check_eq("b2b_exec1_a",    bus.AluA, 32'd1);
        check_eq("b2b_exec1_rdy",  {31'd0, bus.oReady}, 32'd0);
        @(negedge clk);
        check_eq("b2b_wb1_done",   {31'd0, bus.Done}, 32'd1);
        check_eq("b2b_wb1_rdy",    {31'd0, bus.oReady}, 32'd0);
        @(negedge clk);
        check_eq("b2b_idle_ctrl",  {29'd0, bus.AluCtrl}, 32'd0);
        check_eq("b2b_idle_rdy",   {31'd0, bus.oReady}, 32'd1);
        check_eq("b2b_idle_done",  {31'd0, bus.Done}, 32'd0);
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        @(negedge clk);
        check_eq("b2b_exec2_ctrl", {29'd0, bus.AluCtrl}, 32'd3);
        check_eq("b2b_exec2_a",    bus.AluA, 32'd2);
        check_eq("b2b_exec2_b",    bus.AluB, 32'd1);
        @(negedge clk);
        check_eq("b2b_wb2_done",   {31'd0, bus.Done}, 32'd1);
        @(negedge clk);
        dbg_check("b2b_r3", 3'd3, 32'd2);
        dbg_check("b2b_r4", 3'd4, 32'd3);

        // Asynchronous reset during EXEC aborts the command
        @(negedge clk);
        bus.Op = 3'b000; bus.Rd = 3'd5; bus.Rs1 = 3'd2; bus.Rs2 = 3'd2;
        bus.DbgAddr = 3'd5;
        bus.iValid = 1'b1;
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        @(negedge clk);
        check_eq("rstx_exec_rdy", {31'd0, bus.oReady}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstx_rdy_now",  {31'd0, bus.oReady}, 32'd1);
        check_eq("rstx_done_now", {31'd0, bus.Done}, 32'd0);
        check_eq("rstx_alua_now", bus.AluA, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rstx_no_done", {31'd0, bus.Done}, 32'd0);
        end
        dbg_check("rstx_r5", 3'd5, 32'd0);
        for (int i = 0; i < 8; i++) mdl[i] = 32'd0;

        // Normal operation resumes after reset
        preload(3'd1, 32'd9);
        run_cmd("post_rst_add", 3'b000, 3'd2, 3'd1, 3'd1, 32'd9, 32'd9, 32'd18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Register-file and issue controller sitting directly upstream of the ALU: it accepts one-operation commands over a valid/ready handshake, reads two source operands from an internal 8-entry register file, drives the ALU's operand and control inputs, captures the ALU result and overflow, and writes the result back. It also keeps sticky status flags for overflow and illegal opcodes, and provides a combinational debug read port.

## Interface
- N, 32, datapath width; matches the ALU's N
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- iValid  input  1  command valid
- oReady  output  1  controller can accept a command
- Op  input  3  ALU operation code
- Rd  input  3  destination register index
- Rs1  input  3  source register A index
- Rs2  input  3  source register B index
- AluA  output  N  operand A to ALU
- AluB  output  N  operand B to ALU
- AluCtrl  output  3  ALUControl to ALU
- AluResult  input  N  ALU Result
- AluOverflow  input  1  ALU oVerflow
- Done  output  1  one-cycle pulse when a command retires
- OvfFlag  output  1  sticky overflow flag
- ErrFlag  output  1  sticky illegal-opcode flag
- ClrFlags  input  1  synchronous clear of OvfFlag and ErrFlag
- DbgAddr  input  3  debug read index
- DbgData  output  N  combinational read of register DbgAddr

## Operation
- Legal ops: 000 add, 001 sub, 010 and, 011 xor, 101 slt. Illegal ops: 100, 110, 111.
- Register file: 8 x N flops. R0 always reads 0, and writes to R0 are discarded. This applies to DbgData as well.
- FSM states:
  - IDLE: oReady=1. On iValid&&oReady, latch Op/Rd/Rs1/Rs2 and go to EXEC.
  - EXEC: AluA=reg[Rs1], AluB=reg[Rs2], AluCtrl=latched Op. Capture AluResult and AluOverflow into internal registers. Go to WB.
  - WB: write the captured result to reg[Rd] if allowed (see below). Pulse Done. Go to IDLE.
- The write is suppressed for illegal ops. An illegal op sets ErrFlag in WB, and Done still pulses.
- OvfFlag is set in WB when the captured overflow is 1 and Op is 000 or 001.
- Outside EXEC, AluA, AluB and AluCtrl hold 0.
- If ClrFlags is asserted in the same cycle a flag is being set, the set wins.
- Rs1/Rs2 equal to Rd is legal; operands are the pre-write values.
- Reset mid-command aborts the command: no write, no Done, FSM returns to IDLE.

## Timing
- Reset values: oReady=1, Done=0, OvfFlag=0, ErrFlag=0, AluA=0, AluB=0, AluCtrl=0, all registers 0, FSM=IDLE.
- Command accepted at edge T. EXEC occupies cycle T+1, WB occupies cycle T+2. Done is high during T+2, and the written value is visible on DbgData from T+3.
- oReady is low in EXEC and WB. The next command can be accepted at edge T+3, giving throughput of 1 command per 3 cycles.
- iValid while oReady=0 is ignored; the sender must hold the command until it is accepted.
- The ALU is purely combinational: AluResult is sampled in the same EXEC cycle that AluA/AluB are driven.
- DbgData is combinational from DbgAddr and the current register contents. It has no bypass of an in-flight write.

## Configuration
- OVF_TRAP_EN:
  - Defined: an add/sub with AluOverflow=1 does not write Rd. OvfFlag is still set and Done still pulses.
  - Undefined: the wrapped result is written normally and OvfFlag is set.

## Test plan
- Reset, then hold iValid=0 → oReady=1, Done=0, both flags 0, DbgData=0 for all 8 addresses.
- Preload via add from R0: preload R1=5 and R2=7 (e.g. via a test-only preload path into the register file, or a bench-side initialisation of the flops), then issue add R3=R1+R2 → Done at T+2, DbgData[R3]=12 from T+3. Then sub R4=R1-R2 → 0xFFFFFFFE. Then slt R5=R1<R2 → 1.
- Overflow: R1=0x7FFFFFFF, R2=1, issue add R3 → OvfFlag=1.
  - OVF_TRAP_EN undefined: R3=0x80000000.
  - OVF_TRAP_EN defined: R3 unchanged.
  - Next cycle, ClrFlags=1 → OvfFlag=0.
- Illegal Op=110 targeting R6 → ErrFlag=1, Done pulses, R6 unchanged. Write to R0 (add R0=R1+R2) → DbgData[R0] stays 0.
- Back-to-back: iValid held high with two commands → second is accepted exactly 3 cycles after the first. Commands presented while oReady=0 are not accepted.
- Reset asserted asynchronously during EXEC → oReady=1 immediately, no Done, destination register unchanged after reset deasserts.
